spi_session_ctrl: RTL and testbench
===================================

// Module: spi_session_ctrl
// PURPOSE
//  Frame-level sequencer between the SPI slave byte interface and the char automaton.
//  Decodes a command byte at the start of each SSEL frame; forwards payload bytes to the automaton.
//  Pulses the automaton reset on command and buffers automaton output characters in a response FIFO.
//  Schedules the byte presented to MISO: a status byte first, then FIFO data or fill.
// PARAMETERS
//  FIFO_DEPTH  16     response FIFO entries; power of 2, 2..256
//  RST_CYCLES  4      auto_rst_n low time in clk cycles for CMD_RESET, >=1
//  FILL_BYTE   8'h00  MISO byte when there is nothing to send
// PORTS
//  clk            in   1  system clock; all logic on posedge
//  rst_n          in   1  asynchronous active-low reset
//  ssel_active    in   1  synchronized chip-select, high while a frame is in progress
//  rx_valid       in   1  1-cycle pulse: rx_byte holds a complete received byte
//  rx_byte        in   8  received byte, MSB-first assembled
//  tx_take        in   1  1-cycle pulse: slave latched tx_byte into its shifter
//  tx_byte        out  8  next byte the slave shifts out on MISO
//  auto_rst_n     out  1  active-low reset to char automaton
//  auto_valid_in  out  1  1-cycle strobe: auto_char_in is valid
//  auto_char_in   out  8  payload character to automaton
//  auto_valid_out in   1  automaton output strobe
//  auto_char_out  in   8  automaton output character
//  busy           out  1  high when state != IDLE
//  overflow       out  1  sticky: a FIFO push was dropped
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, tx_byte=FILL_BYTE, auto_rst_n=0 then 1 on the 1st cycle after release.
//  Reset: auto_valid_in=0, auto_char_in=0, busy=0, overflow=0.
//  Commands: first rx byte of a frame. 8'h01 RUN, 8'h02 RESET, 8'h03 READ; any other value -> DISCARD.
//  States: IDLE, CMD, RUN, READ, DISCARD, RSTPULSE.
//  - IDLE->CMD on ssel_active rise; tx_byte<=status in that same cycle.
//  - Status byte = {overflow, full, empty, 1'b0, min(count,15)[3:0]}.
//  - CMD: rx_valid with 01->RUN, 03->READ, 02->RSTPULSE, other->DISCARD.
//  - RUN: each rx_valid -> auto_char_in<=rx_byte, auto_valid_in=1 for exactly 1 cycle, 1 clk latency.
//  - READ: rx bytes ignored (dummy). DISCARD: rx bytes ignored until frame end.
//  - RSTPULSE: auto_rst_n=0 for RST_CYCLES clks, FIFO flushed, overflow cleared, then ->DISCARD.
//  - Any state: ssel_active low -> IDLE next cycle. RSTPULSE always completes its full count.
//  - Mid-frame SSEL drop: FIFO contents kept; a partial RUN frame has already-forwarded bytes delivered.
//  TX scheduling, on tx_take:
//  - READ and FIFO not empty: tx_byte<=head, pop. Otherwise tx_byte<=FILL_BYTE.
//  - Taking the status byte (1st take of the frame) clears overflow, unless a drop occurs in the same cycle.
//  - rx_valid(CMD=03) and tx_take in the same cycle: decode first, so the pop applies (byte 2 = data).
//  FIFO:
//  - Push on auto_valid_out, accepted in every state except RSTPULSE.
//  - Push while full with no pop: data dropped, overflow<=1.
//  - Push and pop same cycle: both happen, count unchanged, legal when full.
//  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
//  busy is registered and equals (state!=IDLE).
// TESTING
//  Reset release: outputs match reset values; tx_byte=00; auto_rst_n high by cycle 2.
//  Frame 01,'a','b' -> auto_valid_in pulses carrying 61, 62, each 1 clk after rx_valid; 1st MISO byte=8'h20 (empty).
//  Automaton emits 41,42; frame 03,xx,xx,xx -> MISO 02,41,42,00; FIFO empty afterwards.
//  18 pushes with FIFO_DEPTH=16 -> overflow=1; next status byte=8'hCF; overflow=0 after that take.
//  Frame 02 -> auto_rst_n low exactly 4 clks; FIFO count=0; rest of frame ignored.
//  SSEL drop in RUN after 1 payload byte, then frame 05,'x' -> nothing forwarded, state IDLE after.

Source files
------------

// File: rtl/spi_session_ctrl.sv
// Frame-level sequencer between the SPI slave byte interface and the char automaton:
// decodes the frame command, forwards payload, buffers automaton output and schedules MISO bytes.
module spi_session_ctrl #(
    parameter int         FIFO_DEPTH = 16,
    parameter int         RST_CYCLES = 4,
    parameter logic [7:0] FILL_BYTE  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ssel_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_take,
    output logic [7:0] tx_byte,
    output logic       auto_rst_n,
    output logic       auto_valid_in,
    output logic [7:0] auto_char_in,
    input  logic       auto_valid_out,
    input  logic [7:0] auto_char_out,
    output logic       busy,
    output logic       overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RUN,
        S_READ,
        S_DISCARD,
        S_RSTPULSE
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [RCW-1:0] rst_cnt;
    logic [RCW-1:0] rst_cnt_d;
    logic           first_take;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           empty;
    logic           full;
    logic           frame_start;
    logic           read_mode;
    logic           pop;
    logic           push_req;
    logic           push;
    logic           drop;
    logic           flush;
    logic [8:0]     count_ext;
    logic [3:0]     count_sat;
    logic [7:0]     status;

    always_comb begin
        state_d   = state;
        rst_cnt_d = rst_cnt;
        case (state)
            S_IDLE: begin
                if (ssel_active) state_d = S_CMD;
            end
            S_CMD: begin
                if (!ssel_active) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    case (rx_byte)
                        8'h01: state_d = S_RUN;
                        8'h02: begin
                            state_d   = S_RSTPULSE;
                            rst_cnt_d = RCW'(RST_CYCLES - 1);
                        end
                        8'h03: state_d = S_READ;
                        default: state_d = S_DISCARD;
                    endcase
                end
            end
            S_RUN, S_READ, S_DISCARD: begin
                if (!ssel_active) state_d = S_IDLE;
            end
            S_RSTPULSE: begin
                // The automaton reset pulse is never cut short by a frame end.
                if (rst_cnt == '0) begin
                    state_d = ssel_active ? S_DISCARD : S_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign empty       = (count == '0);
    assign full        = (count == CW'(FIFO_DEPTH));
    assign frame_start = (state == S_IDLE) && ssel_active;
    // A READ command decoded in the same cycle as a take already pops for that take.
    assign read_mode   = (state == S_READ) || ((state == S_CMD) && (state_d == S_READ));
    assign pop         = tx_take && read_mode && !empty;
    assign flush       = (state == S_RSTPULSE);
    assign push_req    = auto_valid_out && !flush;
    assign push        = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;

    assign count_ext = 9'(count);
    assign count_sat = (count_ext > 9'd15) ? 4'hF : count_ext[3:0];
    assign status    = {overflow, full, empty, 1'b0, count_sat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rst_cnt       <= '0;
            first_take    <= 1'b0;
            tx_byte       <= FILL_BYTE;
            auto_rst_n    <= 1'b0;
            auto_valid_in <= 1'b0;
            auto_char_in  <= 8'h00;
            busy          <= 1'b0;
            overflow      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            state         <= state_d;
            rst_cnt       <= rst_cnt_d;
            busy          <= (state_d != S_IDLE);
            auto_rst_n    <= (state_d != S_RSTPULSE);
            auto_valid_in <= (state == S_RUN) && rx_valid;
            if ((state == S_RUN) && rx_valid) auto_char_in <= rx_byte;

            if (frame_start) begin
                tx_byte <= status;
            end else if (tx_take) begin
                tx_byte <= pop ? mem[rd_ptr] : FILL_BYTE;
            end

            if (frame_start) begin
                first_take <= 1'b1;
            end else if (tx_take || (state_d == S_IDLE)) begin
                first_take <= 1'b0;
            end

            // A drop in the same cycle as the status take keeps the flag set.
            if (flush) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end else if (tx_take && first_take) begin
                overflow <= 1'b0;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= auto_char_out;
    end

endmodule

// File: tb/tb_spi_session_ctrl.sv
// Self-checking bench for spi_session_ctrl: cycle vector table, directed corner
// sequences and randomized frames scored against a queue-based frame model.
module tb_spi_session_ctrl;

    localparam int         DEPTH = 16;
    localparam int         RSTC  = 4;
    localparam logic [7:0] FILL  = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ssel_active;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_take;
    logic [7:0] tx_byte;
    logic       auto_rst_n;
    logic       auto_valid_in;
    logic [7:0] auto_char_in;
    logic       auto_valid_out;
    logic [7:0] auto_char_out;
    logic       busy;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    spi_session_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .RST_CYCLES(RSTC),
        .FILL_BYTE (FILL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ssel_active   (ssel_active),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .tx_take       (tx_take),
        .tx_byte       (tx_byte),
        .auto_rst_n    (auto_rst_n),
        .auto_valid_in (auto_valid_in),
        .auto_char_in  (auto_char_in),
        .auto_valid_out(auto_valid_out),
        .auto_char_out (auto_char_out),
        .busy          (busy),
        .overflow      (overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- forwarded-character monitor ----------------
    logic [7:0] fwd_q[$];
    always @(negedge clk) begin
        if (rst_n && auto_valid_in) fwd_q.push_back(auto_char_in);
    end

    // ---------------- reference model state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] m_q[$];
    logic       m_ovf;

    function automatic logic [7:0] model_status();
        int n;
        n = m_q.size();
        return {m_ovf, (n == DEPTH) ? 1'b1 : 1'b0, (n == 0) ? 1'b1 : 1'b0, 1'b0,
                (n > 15) ? 4'hF : 4'(n)};
    endfunction

    function automatic logic [7:0] model_take(input bit is_read);
        if (is_read && m_q.size() > 0) return m_q.pop_front();
        return FILL;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_valid       = 1'b0;
        rx_byte        = 8'h00;
        tx_take        = 1'b0;
        auto_valid_out = 1'b0;
        auto_char_out  = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic take);
        rx_valid = 1'b1;
        rx_byte  = b;
        tx_take  = take;
        step();
        rx_valid = 1'b0;
        tx_take  = 1'b0;
    endtask

    task automatic push_auto(input logic [7:0] b);
        auto_valid_out = 1'b1;
        auto_char_out  = b;
        step();
        auto_valid_out = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       ssel;
        logic       rxv;
        logic [7:0] rxb;
        logic       take;
        logic       avo;
        logic [7:0] aco;
        logic [7:0] e_tx;
        logic       e_avi;
        logic [7:0] e_chr;
        logic       e_arn;
        logic       e_busy;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int lows;
        int kind;
        int n_pay;
        logic [7:0] cmd;
        logic [7:0] b;

        // RUN 01,'a','b'; pushes 41,42; READ 03,xx,xx,xx; status; RESET 02 with ignored push and bytes.
        tbl.push_back('{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h20,1'b0,8'h00,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,8'h01,1'b1,1'b0,8'h00, 8'h00,1'b0,8'h00,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,8'h61,1'b0,1'b0,8'h00, 8'h00,1'b1,8'h61,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h61,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,8'h62,1'b0,1'b0,8'h00, 8'h00,1'b1,8'h62,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h62,1'b1,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,8'h00,1'b0,1'b1,8'h41, 8'h00,1'b0,8'h62,1'b1,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,8'h00,1'b0,1'b1,8'h42, 8'h00,1'b0,8'h62,1'b1,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h62,1'b1,1'b0,1'b0});
        tbl.push_back('{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h02,1'b0,8'h62,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,8'h03,1'b1,1'b0,8'h00, 8'h41,1'b0,8'h62,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,8'hFF,1'b1,1'b0,8'h00, 8'h42,1'b0,8'h62,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,8'hFF,1'b1,1'b0,8'h00, 8'h00,1'b0,8'h62,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h62,1'b1,1'b0,1'b0});
        tbl.push_back('{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h20,1'b0,8'h62,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,8'h02,1'b1,1'b0,8'h00, 8'h00,1'b0,8'h62,1'b0,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,8'h55,1'b0,1'b1,8'h77, 8'h00,1'b0,8'h62,1'b0,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h62,1'b0,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h62,1'b0,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,8'h01,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h62,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,8'h61,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h62,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h62,1'b1,1'b0,1'b0});
        tbl.push_back('{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h20,1'b0,8'h62,1'b1,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00, 8'h20,1'b0,8'h62,1'b1,1'b0,1'b0});

        // ---------------- reset ----------------
        rst_n       = 1'b0;
        ssel_active = 1'b0;
        idle_inputs();
        step();
        step();
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_auto_rst_n", auto_rst_n, 1'b0);
        check("rst_auto_valid_in", auto_valid_in, 1'b0);
        check("rst_auto_char_in", auto_char_in, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        step();
        check("rel_auto_rst_n", auto_rst_n, 1'b1);
        check("rel_tx_byte", tx_byte, 8'h00);
        check("rel_busy", busy, 1'b0);
        step();

        // ---------------- table ----------------
        fwd_q.delete();
        for (int i = 0; i < tbl.size(); i++) begin
            ssel_active    = tbl[i].ssel;
            rx_valid       = tbl[i].rxv;
            rx_byte        = tbl[i].rxb;
            tx_take        = tbl[i].take;
            auto_valid_out = tbl[i].avo;
            auto_char_out  = tbl[i].aco;
            step();
            check($sformatf("tbl%0d_tx_byte", i), tx_byte, tbl[i].e_tx);
            check($sformatf("tbl%0d_auto_valid_in", i), auto_valid_in, tbl[i].e_avi);
            check($sformatf("tbl%0d_auto_char_in", i), auto_char_in, tbl[i].e_chr);
            check($sformatf("tbl%0d_auto_rst_n", i), auto_rst_n, tbl[i].e_arn);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].e_ovf);
        end
        idle_inputs();
        ssel_active = 1'b0;
        step();
        check("tbl_fwd_count", fwd_q.size(), 2);

        // ---------------- overflow: 18 pushes, status CF, cleared by take ----------------
        for (int i = 0; i < 18; i++) push_auto(8'h80 + 8'(i));
        check("ovf_set", overflow, 1'b1);
        ssel_active = 1'b1;
        step();
        check("ovf_status", tx_byte, 8'hCF);
        send_byte(8'h03, 1'b1);
        check("ovf_first_data", tx_byte, 8'h80);
        check("ovf_cleared", overflow, 1'b0);
        for (int i = 1; i < 16; i++) begin
            send_byte(8'hFF, 1'b1);
            check($sformatf("ovf_drain%0d", i), tx_byte, 8'h80 + 8'(i));
        end
        send_byte(8'hFF, 1'b1);
        check("ovf_drain_fill", tx_byte, FILL);
        ssel_active = 1'b0;
        step();
        check("ovf_end_busy", busy, 1'b0);

        // ---------------- drop in the same cycle as the status take ----------------
        for (int i = 0; i < 17; i++) push_auto(8'hC0 + 8'(i));
        ssel_active = 1'b1;
        step();
        check("drop_status", tx_byte, 8'hCF);
        auto_valid_out = 1'b1;
        auto_char_out  = 8'hAA;
        send_byte(8'h01, 1'b1);
        auto_valid_out = 1'b0;
        check("drop_keeps_ovf", overflow, 1'b1);
        tx_take = 1'b1;
        step();
        tx_take = 1'b0;
        check("second_take_keeps_ovf", overflow, 1'b1);
        ssel_active = 1'b0;
        step();
        ssel_active = 1'b1;
        step();
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 6; i++) step();
        ssel_active = 1'b0;
        step();
        check("rstframe_ovf_clear", overflow, 1'b0);
        ssel_active = 1'b1;
        step();
        check("rstframe_status_empty", tx_byte, 8'h20);
        ssel_active = 1'b0;
        step();

        // ---------------- SSEL drop mid RUN, then unknown command ----------------
        fwd_q.delete();
        ssel_active = 1'b1;
        step();
        send_byte(8'h01, 1'b0);
        send_byte(8'h70, 1'b0);
        check("drop_run_avi", auto_valid_in, 1'b1);
        check("drop_run_chr", auto_char_in, 8'h70);
        ssel_active = 1'b0;
        step();
        check("drop_run_idle", busy, 1'b0);
        step();
        ssel_active = 1'b1;
        step();
        send_byte(8'h05, 1'b0);
        send_byte(8'h78, 1'b0);
        step();
        check("discard_no_avi", auto_valid_in, 1'b0);
        ssel_active = 1'b0;
        step();
        check("discard_idle", busy, 1'b0);
        check("discard_fwd_count", fwd_q.size(), 1);
        if (fwd_q.size() > 0) check("discard_fwd_byte", fwd_q[0], 8'h70);

        // ---------------- randomized frames vs. frame model ----------------
        m_q.delete();
        m_ovf = 1'b0;
        for (int f = 0; f < 80; f++) begin
            for (int p = $urandom_range(0, 8); p > 0; p--) begin
                b = 8'($urandom);
                push_auto(b);
                if (m_q.size() < DEPTH) m_q.push_back(b);
                else m_ovf = 1'b1;
            end
            kind = $urandom_range(0, 3);
            case (kind)
                0:       cmd = 8'h01;
                1:       cmd = 8'h03;
                2:       cmd = 8'h02;
                default: cmd = 8'($urandom_range(4, 255));
            endcase
            fwd_q.delete();
            exp_q.delete();
            ssel_active = 1'b1;
            step();
            check($sformatf("rnd%0d_status", f), tx_byte, model_status());
            send_byte(cmd, 1'b1);
            m_ovf = 1'b0;
            check($sformatf("rnd%0d_take0", f), tx_byte, model_take(kind == 1));
            if (kind == 2) begin
                lows = 0;
                for (int c = 0; c < 8; c++) begin
                    if (!auto_rst_n) lows++;
                    step();
                end
                check($sformatf("rnd%0d_rst_low", f), lows, RSTC);
                m_q.delete();
            end
            n_pay = $urandom_range(0, 5);
            for (int j = 0; j < n_pay; j++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) step();
                b = 8'($urandom);
                send_byte(b, 1'b1);
                if (kind == 0) exp_q.push_back(b);
                check($sformatf("rnd%0d_take%0d", f, j + 1), tx_byte, model_take(kind == 1));
            end
            step();
            ssel_active = 1'b0;
            step();
            check($sformatf("rnd%0d_busy_end", f), busy, 1'b0);
            step();
            check($sformatf("rnd%0d_fwd_count", f), fwd_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < fwd_q.size(); k++)
                check($sformatf("rnd%0d_fwd%0d", f, k), fwd_q[k], exp_q[k]);
        end

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
